cpm_fifo_arb: RTL and testbench

CPM_FIFO_ARB -- requirements
Module: cpm_fifo_arb

---
 rtl/cpm_fifo_arb.sv | 113 +++++++++++
 tb/tb_cpm_fifo_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpm_fifo_arb.sv
// rtl/cpm_fifo_arb.sv - round-robin burst arbiter feeding a shared FIFO, with flush/clear sequencing
module cpm_fifo_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 2,
   parameter int BURST_MAX  = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_vld,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_dat,
   output logic [NUM_REQ-1:0]             req_rdy,
   input  logic                           flush_req,
   output logic                           flush_done,
   output logic                           fifo_push,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
   output logic                           fifo_pop,
   input  logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_dout,
   input  logic                           fifo_empty,
   input  logic                           fifo_full,
   output logic                           fifo_clr,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic [DATA_WIDTH-1:0]          out_dat,
   output logic [ID_WIDTH-1:0]            out_id,
   output logic [ID_WIDTH-1:0]            gnt_id,
   output logic                           busy
);

   typedef enum logic [1:0] {IDLE, GRANT, FLUSH, CLEAR} state_t;

   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt, gnt_id_nxt, arb_idx;
   logic [7:0]          beat_cnt, beat_cnt_nxt;
   logic [DATA_WIDTH-1:0] dat_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign dat_arr[g] = req_dat[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Walk from the highest offset down so the nearest requester after rr_ptr wins.
   always_comb begin
      logic [ID_WIDTH-1:0] idx;
      arb_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
         if (req_vld[idx]) arb_idx = idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         gnt_id   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         gnt_id   <= gnt_id_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      gnt_id_nxt   = gnt_id;
      beat_cnt_nxt = beat_cnt;
      req_rdy      = '0;
      fifo_push    = 1'b0;
      fifo_clr     = 1'b0;
      flush_done   = 1'b0;
      case (state)
         IDLE: begin
            if (flush_req) begin
               state_nxt = FLUSH;
            end else if (|req_vld) begin
               state_nxt    = GRANT;
               gnt_id_nxt   = arb_idx;
               beat_cnt_nxt = '0;
            end
         end
         GRANT: begin
            // A full FIFO only stalls the burst; it never terminates it.
            req_rdy[gnt_id] = !fifo_full;
            fifo_push       = req_vld[gnt_id] & !fifo_full;
            if ((fifo_push && beat_cnt == 8'(BURST_MAX - 1)) || !req_vld[gnt_id]) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end else if (fifo_push) begin
               beat_cnt_nxt = beat_cnt + 8'd1;
            end
         end
         FLUSH: begin
            if (fifo_empty && !fifo_push) state_nxt = CLEAR;
         end
         CLEAR: begin
            fifo_clr   = 1'b1;
            flush_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fifo_din          = {gnt_id, dat_arr[gnt_id]};
   assign out_vld           = !fifo_empty;
   assign {out_id, out_dat} = fifo_dout;
   assign fifo_pop          = out_vld & out_rdy;
   assign busy              = (state != IDLE);

endmodule

// File: tb/tb_cpm_fifo_arb.sv
// tb/tb_cpm_fifo_arb.sv - directed self-checking bench for cpm_fifo_arb with a 16-deep FIFO model
module tb_cpm_fifo_arb;
   localparam int N  = 4;
   localparam int DW = 64;
   localparam int IW = 2;
   localparam int BM = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_vld;
   logic [N*DW-1:0] req_dat;
   logic [N-1:0]    req_rdy;
   logic            flush_req, flush_done;
   logic            fifo_push, fifo_pop, fifo_clr;
   logic [IW+DW-1:0] fifo_din, fifo_dout;
   logic            fifo_empty, fifo_full;
   logic            out_vld, out_rdy;
   logic [DW-1:0]   out_dat;
   logic [IW-1:0]   out_id, gnt_id;
   logic            busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cpm_fifo_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_dat(req_dat), .req_rdy(req_rdy),
      .flush_req(flush_req), .flush_done(flush_done), .fifo_push(fifo_push),
      .fifo_din(fifo_din), .fifo_pop(fifo_pop), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_clr(fifo_clr),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_id(out_id),
      .gnt_id(gnt_id), .busy(busy)
   );

   // 16-deep shared FIFO model
   logic [IW+DW-1:0] mem [16];
   logic [3:0] wp = '0, rp = '0;
   logic [4:0] cnt = '0;
   int tot_push = 0;
   wire push_ok = fifo_push && (cnt != 5'd16);
   wire pop_ok  = fifo_pop && (cnt != 5'd0);
   assign fifo_dout  = mem[rp];
   assign fifo_empty = (cnt == 5'd0);
   assign fifo_full  = (cnt == 5'd16);

   always @(posedge clk) begin
      if (fifo_push) tot_push <= tot_push + 1;
      if (fifo_clr) begin
         wp <= '0; rp <= '0; cnt <= '0;
      end else begin
         if (push_ok) begin mem[wp] <= fifo_din; wp <= wp + 4'd1; end
         if (pop_ok) rp <= rp + 4'd1;
         cnt <= cnt + 5'(push_ok) - 5'(pop_ok);
      end
   end

   function automatic logic [DW-1:0] pay(input int i);
      return 64'hD00D_0000_0000_0000 + 64'(i) * 64'h1111;
   endfunction

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int np, pops, pushes, seen, p0;

   initial begin
      rst_n = 1'b0; req_vld = '0; flush_req = 1'b0; out_rdy = 1'b0;
      for (int i = 0; i < N; i++) req_dat[i*DW +: DW] = pay(i);
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_rdy", req_rdy, 0);
      check("rst_push", fifo_push, 0);
      check("rst_clr", fifo_clr, 0);
      check("rst_done", flush_done, 0);
      check("rst_gnt", gnt_id, 0);
      check("rst_out_vld", out_vld, 0);

      // Round robin across all four producers, full bursts
      @(negedge clk); rst_n = 1'b1; req_vld = 4'b1111; out_rdy = 1'b1; #1;
      check("rr_idle0", busy, 0);
      for (int j = 0; j < 24; j++) begin
         @(negedge clk); #1;
         if (j % 5 == 4) begin
            check("rr_gap_push", fifo_push, 0);
            check("rr_gap_busy", busy, 0);
         end else begin
            check("rr_push", fifo_push, 1);
            check("rr_id", fifo_din[IW+DW-1:DW], (j / 5) % 4);
         end
         if (j == 0) check("rr_din_dat", fifo_din[DW-1:0], pay(0));
         if (j == 1) begin
            check("rr_out_vld", out_vld, 1);
            check("rr_out_id", out_id, 0);
            check("rr_out_dat", out_dat, pay(0));
         end
      end
      @(negedge clk); req_vld = '0;
      repeat (4) @(negedge clk);

      // Short burst from producer 2, then rr_ptr must sit at 3
      req_vld = 4'b0100; #1;
      check("s_idle", busy, 0);
      @(negedge clk); #1;
      check("s_push1", fifo_push, 1);
      check("s_id1", fifo_din[IW+DW-1:DW], 2);
      @(negedge clk); #1;
      check("s_push2", fifo_push, 1);
      check("s_out_id", out_id, 2);
      check("s_out_dat", out_dat, pay(2));
      check("s_pop", fifo_pop, 1);
      @(negedge clk); req_vld = '0; #1;
      check("s_drop_push", fifo_push, 0);
      check("s_drop_busy", busy, 1);
      @(negedge clk); req_vld = 4'b1111; #1;
      check("s_back_idle", busy, 0);
      @(negedge clk); #1;
      check("s_next_gnt", gnt_id, 3);
      check("s_next_push", fifo_push, 1);
      @(negedge clk); req_vld = '0; #1;
      check("s_end_push", fifo_push, 0);
      repeat (5) @(negedge clk);
      check("s_drained", cnt, 0);

      // Fill the FIFO from producer 1 with the consumer stalled
      out_rdy = 1'b0; req_vld = 4'b0010;
      np = 0;
      for (int c = 0; c < 40 && np < 16; c++) begin
         #1;
         if (fifo_push) np++;
         @(negedge clk);
      end
      check("full_np", np, 16);
      #1;
      check("full_cnt", cnt, 16);
      check("full_flag_idle", busy, 0);
      @(negedge clk); #1;
      check("full_gnt", gnt_id, 1);
      check("full_busy", busy, 1);
      check("full_rdy", req_rdy, 0);
      check("full_push", fifo_push, 0);
      @(negedge clk); out_rdy = 1'b1; #1;
      check("full_pop", fifo_pop, 1);
      check("full_pop_nopush", fifo_push, 0);
      @(negedge clk); out_rdy = 1'b0; #1;
      check("full_resume_push", fifo_push, 1);
      check("full_resume_rdy", req_rdy, 4'b0010);
      @(negedge clk); req_vld = '0; out_rdy = 1'b1;
      repeat (20) @(negedge clk);
      check("full_drained", cnt, 0);

      // Five entries, then flush with producer 1 still requesting
      out_rdy = 1'b0; req_vld = 4'b0001;
      for (int c = 0; c < 20 && cnt != 5'd5; c++) @(negedge clk);
      check("fl_fill", cnt, 5);
      req_vld = 4'b0010; flush_req = 1'b1; out_rdy = 1'b1;
      pops = 0; pushes = 0; seen = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         pops   += int'(fifo_pop);
         pushes += int'(fifo_push);
         if (flush_done) begin
            check("fl_clr_with_done", fifo_clr, 1);
            seen = 1;
            break;
         end
         if (fifo_clr) check("fl_clr_alone", fifo_clr, 0);
         @(negedge clk);
      end
      check("fl_seen", seen, 1);
      check("fl_pops", pops, 5);
      check("fl_pushes", pushes, 0);
      @(negedge clk); #1;
      check("fl_done_1cyc", flush_done, 0);
      check("fl_clr_1cyc", fifo_clr, 0);
      check("fl_idle", busy, 0);
      @(negedge clk); #1;
      check("fl2_busy", busy, 1);
      check("fl2_nopush", fifo_push, 0);
      @(negedge clk); #1;
      check("fl2_done", flush_done, 1);
      check("fl2_clr", fifo_clr, 1);
      @(negedge clk); flush_req = 1'b0; req_vld = '0;
      repeat (2) @(negedge clk);

      // Reset in the middle of a burst to producer 3
      req_vld = 4'b1000; out_rdy = 1'b1; #1;
      check("rb_idle", busy, 0);
      @(negedge clk); #1;
      check("rb_gnt", gnt_id, 3);
      check("rb_push1", fifo_push, 1);
      @(negedge clk); rst_n = 1'b0; #1;
      p0 = tot_push;
      check("rb_push_rst", fifo_push, 0);
      check("rb_busy_rst", busy, 0);
      check("rb_rdy_rst", req_rdy, 0);
      check("rb_gnt_rst", gnt_id, 0);
      check("rb_out_vld_rst", out_vld, 1);
      check("rb_pop_rst", fifo_pop, 1);
      @(negedge clk); #1;
      check("rb_push_rst2", fifo_push, 0);
      @(negedge clk); rst_n = 1'b1; req_vld = 4'b1111; #1;
      check("rb_no_push", tot_push, p0);
      check("rb_idle_after", busy, 0);
      @(negedge clk); #1;
      check("rb_rr0", gnt_id, 0);
      check("rb_busy_after", busy, 1);
      @(negedge clk); req_vld = '0;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
